// File: rtl/heartbeat_pulse_gen.sv
// heartbeat_pulse_gen: synthetic heartbeat source for bench and bring-up builds.
// The BPM request is clamped, then divided into a beat period by a 32-step
// restoring divider. A high/low pulse machine emits one beat per period and
// counts the beats.
//
// Optional build macro: HEARTBEAT_BOUNCE_EN. When it is defined, each beat_out
// pulse starts with four BOUNCE_CYC-long segments (1,0,1,0) of contact bounce.
// beat_led, beat_count and the period are the same in both builds.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset; overrides every other input
//   enable     level; 1 = generate beats
//   bpm        requested beats per minute; sampled only when bpm_load is high
//   bpm_load   one-cycle strobe that latches bpm and starts a period computation
//   busy       high while the divider runs (32 cycles)
//   beat_out   pulse to the heart-rate counter button input
//   beat_led   clean pulse envelope for the sensor-board LED
//   period_cyc current beat period in clk cycles
//   beat_count beats emitted since reset; saturates at all-ones
module heartbeat_pulse_gen #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned PULSE_CYC  = 5000000,
    parameter int unsigned BPM_MIN    = 30,
    parameter int unsigned BPM_MAX    = 240,
    parameter int unsigned BOUNCE_CYC = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  bpm,
    input  logic        bpm_load,
    output logic        busy,
    output logic        beat_out,
    output logic        beat_led,
    output logic [31:0] period_cyc,
    output logic [17:0] beat_count
);

    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned BPM_W    = 8;
    localparam int unsigned COUNT_W  = 18;
    localparam int unsigned ITER_W   = 5;

    localparam logic [PERIOD_W-1:0] DIVIDEND   = PERIOD_W'(60 * CLK_HZ);
    localparam logic [PERIOD_W-1:0] PULSE_LEN  = PERIOD_W'(PULSE_CYC);
    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_CYC - 1);
    localparam logic [BPM_W-1:0]    BPM_LO     = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0]    BPM_HI     = BPM_W'(BPM_MAX);
    localparam logic [ITER_W-1:0]   ITER_LAST  = ITER_W'(31);
    localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;

    // Parameter sanity: the low phase must be at least one cycle long and the
    // bounce preamble must fit inside the pulse.
    if ((60 * CLK_HZ) / BPM_MAX <= PULSE_CYC) begin : g_bad_pulse
        $error("heartbeat_pulse_gen: PULSE_CYC must be shorter than the shortest period");
    end
    if (4 * BOUNCE_CYC >= PULSE_CYC) begin : g_bad_bounce
        $error("heartbeat_pulse_gen: 4*BOUNCE_CYC must be shorter than PULSE_CYC");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    state_t               state;
    logic                 pending;
    logic [BPM_W-1:0]     bpm_lat;
    logic [PERIOD_W-1:0]  dq;       // dividend bits shift out, quotient bits shift in
    logic [BPM_W-1:0]     rem;
    logic [ITER_W-1:0]    iter;
    logic [PERIOD_W-1:0]  cnt;

    logic [BPM_W-1:0]     bpm_clamped_c;
    logic [BPM_W:0]       rem_sh_c;
    logic [BPM_W:0]       rem_diff_c;
    logic                 q_bit_c;
    logic [PERIOD_W-1:0]  low_last_c;

    // Clamp the request so the divider never sees zero.
    always_comb begin
        bpm_clamped_c = bpm;
        if (bpm < BPM_LO) begin
            bpm_clamped_c = BPM_LO;
        end else if (bpm > BPM_HI) begin
            bpm_clamped_c = BPM_HI;
        end
    end

    // One restoring-divide step. The remainder stays below the divisor, so the
    // 9-bit trial difference is negative exactly when the shifted remainder
    // is smaller than the divisor.
    always_comb begin
        rem_sh_c   = {rem, dq[PERIOD_W-1]};
        rem_diff_c = rem_sh_c - {1'b0, bpm_lat};
        q_bit_c    = ~rem_diff_c[BPM_W];
    end

    assign low_last_c = period_cyc - PULSE_LEN - PERIOD_W'(1);

`ifdef HEARTBEAT_BOUNCE_EN
    // beat_out level at a given offset into the high phase.
    function automatic logic bounce_level(input logic [PERIOD_W-1:0] offs);
        logic lvl;
        if (offs < PERIOD_W'(BOUNCE_CYC)) begin
            lvl = 1'b1;
        end else if (offs < PERIOD_W'(2 * BOUNCE_CYC)) begin
            lvl = 1'b0;
        end else if (offs < PERIOD_W'(3 * BOUNCE_CYC)) begin
            lvl = 1'b1;
        end else if (offs < PERIOD_W'(4 * BOUNCE_CYC)) begin
            lvl = 1'b0;
        end else begin
            lvl = 1'b1;
        end
        return lvl;
    endfunction
`endif

    // Pulse machine, divider and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            bpm_lat    <= '0;
            dq         <= '0;
            rem        <= '0;
            iter       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            beat_out   <= 1'b0;
            beat_led   <= 1'b0;
            period_cyc <= '0;
            beat_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bpm_load) begin
                        bpm_lat <= bpm_clamped_c;
                        state   <= DIVIDE;
                        busy    <= 1'b1;
                        dq      <= DIVIDEND;
                        rem     <= '0;
                        iter    <= '0;
                        pending <= 1'b0;
                    end else if (enable && (period_cyc != '0)) begin
                        state    <= HIGH;
                        beat_out <= 1'b1;
                        beat_led <= 1'b1;
                        cnt      <= '0;
                        if (beat_count != COUNT_MAX) begin
                            beat_count <= beat_count + COUNT_W'(1);
                        end
                    end
                end

                // Strobes are ignored here; the divisor is frozen in bpm_lat.
                DIVIDE: begin
                    dq   <= {dq[PERIOD_W-2:0], q_bit_c};
                    rem  <= q_bit_c ? rem_diff_c[BPM_W-1:0] : rem_sh_c[BPM_W-1:0];
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_LAST) begin
                        busy       <= 1'b0;
                        period_cyc <= {dq[PERIOD_W-2:0], q_bit_c};
                        if (enable) begin
                            state    <= HIGH;
                            beat_out <= 1'b1;
                            beat_led <= 1'b1;
                            cnt      <= '0;
                            if (beat_count != COUNT_MAX) begin
                                beat_count <= beat_count + COUNT_W'(1);
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                // The high phase always runs to completion; a strobe here is
                // remembered (latest value wins) and serviced afterwards.
                HIGH: begin
                    if (bpm_load) begin
                        bpm_lat <= bpm_clamped_c;
                        pending <= 1'b1;
                    end
                    if (cnt == PULSE_LAST) begin
                        beat_out <= 1'b0;
                        beat_led <= 1'b0;
                        cnt      <= '0;
                        if (pending || bpm_load) begin
                            state   <= DIVIDE;
                            busy    <= 1'b1;
                            dq      <= DIVIDEND;
                            rem     <= '0;
                            iter    <= '0;
                            pending <= 1'b0;
                        end else if (!enable) begin
                            state <= IDLE;
                        end else begin
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
`ifdef HEARTBEAT_BOUNCE_EN
                        beat_out <= bounce_level(cnt + PERIOD_W'(1));
`endif
                    end
                end

                LOW: begin
                    if (bpm_load) begin
                        bpm_lat <= bpm_clamped_c;
                        state   <= DIVIDE;
                        busy    <= 1'b1;
                        dq      <= DIVIDEND;
                        rem     <= '0;
                        iter    <= '0;
                        pending <= 1'b0;
                    end else if (!enable) begin
                        state <= IDLE;
                    end else if (cnt == low_last_c) begin
                        state    <= HIGH;
                        beat_out <= 1'b1;
                        beat_led <= 1'b1;
                        cnt      <= '0;
                        if (beat_count != COUNT_MAX) begin
                            beat_count <= beat_count + COUNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
